note_sprite_sequencer: RTL and testbench

Draw sequencer for the note layer of the rhythm-game display. Walks the note table (X/Y location ROMs and key ROM, 16 entries), and for each note scans its 16×16 key sprite out of the sprite ROMs, producing a pixel-per-cycle plot stream for the VGA adapter. Sits between the game FSM (which pulses `start` once per frame) and the VGA adapter. Owns the read ports of the location, key and sprite ROMs while busy.

---
 rtl/note_sprite_sequencer_if.sv | 33 +++
 rtl/note_sprite_sequencer.sv | 137 +++++++++++++
 tb/tb_note_sprite_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/note_sprite_sequencer_if.sv
// Signal bundle between note_sprite_sequencer, its ROMs, the game FSM and the VGA adapter.
// slave = the sequencer side, master = the environment (FSM, ROMs, VGA adapter).
interface note_sprite_sequencer_if;
  logic       start;
  logic [2:0] frame;
  logic [3:0] note_addr;
  logic [7:0] loc_x;
  logic [7:0] loc_y;
  logic [1:0] key_id;
  logic [3:0] spr_i;
  logic [5:0] spr_j;
  logic [2:0] spr_id;
  logic [1:0] spr_key;
  logic [2:0] pix_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  modport slave (
    input  start, frame, loc_x, loc_y, key_id, pix_colour,
    output note_addr, spr_i, spr_j, spr_id, spr_key,
           vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport master (
    output start, frame, loc_x, loc_y, key_id, pix_colour,
    input  note_addr, spr_i, spr_j, spr_id, spr_key,
           vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/note_sprite_sequencer.sv
// Walks the note table and scans each note's key sprite into a pixel-per-cycle VGA plot stream.
// Optional NOTE_TRANSPARENT_EN: colour 0 pixels are not plotted so the background shows through.
//
// state | meaning
// IDLE  | waiting for start; note_addr parked at 0
// FETCH | note_addr = n presented to location/key ROMs
// LATCH | ROM data captured into base_x/base_y/spr_key; i, j cleared
// DRAW  | one sprite address per cycle, row-major over SPR x SPR
// DRAIN | last pixel leaves the pipeline; advance note or finish
// DONE  | one-cycle done pulse, then IDLE
module note_sprite_sequencer #(
  parameter int NOTES = 16,
  parameter int SPR   = 16
) (
  input  logic clock,
  input  logic reset,
  note_sprite_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] DRAW  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [3:0] LAST_N = 4'(NOTES - 1);
  localparam logic [3:0] LAST_P = 4'(SPR - 1);

  logic [2:0] state;
  logic [3:0] n;
  logic [3:0] i;
  logic [3:0] j;
  logic [7:0] base_x;
  logic [7:0] base_y;
  logic [2:0] frame_q;
  logic [1:0] key_q;
  logic       pix_valid;
  logic       clip_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic       visible;

  // Nine-bit sums so a note near the right/bottom edge clips instead of wrapping.
  assign sum_x = {1'b0, base_x} + {5'b0, i};
  assign sum_y = {1'b0, base_y} + {5'b0, j};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n         <= '0;
      i         <= '0;
      j         <= '0;
      base_x    <= '0;
      base_y    <= '0;
      frame_q   <= '0;
      key_q     <= '0;
      pix_valid <= 1'b0;
      clip_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      pix_valid <= (state == DRAW);
      if (state == DRAW) begin
        x_q    <= sum_x[7:0];
        y_q    <= sum_y[6:0];
        clip_q <= (sum_x > 9'd159) || (sum_y > 9'd119);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            frame_q <= bus.frame;
            n       <= '0;
            state   <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          base_x <= bus.loc_x;
          base_y <= bus.loc_y;
          key_q  <= bus.key_id;
          i      <= '0;
          j      <= '0;
          state  <= DRAW;
        end
        DRAW: begin
          if (i == LAST_P) begin
            i <= '0;
            if (j == LAST_P) begin
              j     <= '0;
              state <= DRAIN;
            end else begin
              j <= j + 4'd1;
            end
          end else begin
            i <= i + 4'd1;
          end
        end
        DRAIN: begin
          if (n == LAST_N) begin
            state <= DONE;
          end else begin
            n     <= n + 4'd1;
            state <= FETCH;
          end
        end
        DONE: begin
          n     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOTE_TRANSPARENT_EN
  assign visible = |bus.pix_colour;
`else
  assign visible = 1'b1;
`endif

  assign bus.note_addr  = n;
  assign bus.spr_i      = i;
  assign bus.spr_j      = {2'b00, j};
  assign bus.spr_id     = frame_q;
  assign bus.spr_key    = key_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  // Sprite ROM data arrives in the cycle after the address, alongside the registered x/y.
  assign bus.vga_colour = pix_valid ? bus.pix_colour : 3'b000;
  assign bus.vga_plot   = pix_valid & ~clip_q & visible;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_note_sprite_sequencer.sv
// Directed bench for note_sprite_sequencer: ROM models, expected-pixel queue, pass timing checks.
module tb_note_sprite_sequencer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  note_sprite_sequencer_if bus ();
  note_sprite_sequencer_if bus1 ();

  note_sprite_sequencer #(.NOTES(16), .SPR(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  note_sprite_sequencer #(.NOTES(1), .SPR(16)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  int tests = 0;
  int failed = 0;

  logic [7:0] rom_x [16];
  logic [7:0] rom_y [16];
  logic [1:0] rom_key [16];
  int spr_mode = 0;

  logic [17:0] exp_q [$];
  int busy_cycles, done_count, plots, first_exp;
  int plots_note [16];

  // Selected instance (0 = 16-note dut, 1 = single-note dut1).
  logic sel = 1'b0;
  logic       s_done, s_busy, s_plot;
  logic [3:0] s_note_addr;
  logic [5:0] s_spr_j;
  logic [2:0] s_spr_id;
  logic [1:0] s_spr_key;
  logic [17:0] s_pix;
  assign s_done      = sel ? bus1.done : bus.done;
  assign s_busy      = sel ? bus1.busy : bus.busy;
  assign s_plot      = sel ? bus1.vga_plot : bus.vga_plot;
  assign s_note_addr = sel ? bus1.note_addr : bus.note_addr;
  assign s_spr_j     = sel ? bus1.spr_j : bus.spr_j;
  assign s_spr_id    = sel ? bus1.spr_id : bus.spr_id;
  assign s_spr_key   = sel ? bus1.spr_key : bus.spr_key;
  assign s_pix       = sel ? {bus1.vga_x, bus1.vga_y, bus1.vga_colour}
                           : {bus.vga_x, bus.vga_y, bus.vga_colour};

  function automatic logic [2:0] spr_fn(logic [1:0] key, logic [2:0] id, logic [3:0] i, logic [3:0] j);
    if (spr_mode == 1) return i[0] ? 3'd5 : 3'd0;
    return 3'(((int'(i) + int'(j) + int'(key) + int'(id)) % 7) + 1);
  endfunction

  function automatic bit vis(logic [2:0] c);
`ifdef NOTE_TRANSPARENT_EN
    return c != 3'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Synchronous ROM models, one-cycle latency.
  always @(posedge clock) begin
    bus.loc_x       <= rom_x[bus.note_addr];
    bus.loc_y       <= rom_y[bus.note_addr];
    bus.key_id      <= rom_key[bus.note_addr];
    bus.pix_colour  <= spr_fn(bus.spr_key, bus.spr_id, bus.spr_i, bus.spr_j[3:0]);
    bus1.loc_x      <= rom_x[bus1.note_addr];
    bus1.loc_y      <= rom_y[bus1.note_addr];
    bus1.key_id     <= rom_key[bus1.note_addr];
    bus1.pix_colour <= spr_fn(bus1.spr_key, bus1.spr_id, bus1.spr_i, bus1.spr_j[3:0]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (s_busy) busy_cycles++;
      if (s_done) done_count++;
      if (s_plot) begin
        plots++;
        plots_note[s_note_addr]++;
        check("plot_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("pixel_xyc", 64'(s_pix), 64'(exp_q.pop_front()));
        check("plot_while_busy", 64'(s_busy), 64'd1);
      end
    end
  end

  task automatic push_pass(input int notes, input logic [2:0] frame);
    exp_q.delete();
    first_exp = -1;
    for (int n = 0; n < notes; n++)
      for (int j = 0; j < 16; j++)
        for (int i = 0; i < 16; i++) begin
          int x, y;
          logic [2:0] c;
          x = int'(rom_x[n]) + i;
          y = int'(rom_y[n]) + j;
          c = spr_fn(rom_key[n], frame, 4'(i), 4'(j));
          if (x <= 159 && y <= 119 && vis(c)) begin
            exp_q.push_back({8'(x), 7'(y), c});
            if (first_exp < 0) first_exp = n * 259 + 3 + j * 16 + i;
          end
        end
  endtask

  task automatic drive_start(input logic v, input logic [2:0] f);
    if (sel) begin bus1.start = v; bus1.frame = f; end
    else begin bus.start = v; bus.frame = f; end
  endtask

  task automatic check_zero(input string tag);
    check(tag, 64'({bus.note_addr, bus.spr_i, bus.spr_j, bus.spr_id, bus.spr_key, bus.vga_x,
                    bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done}), 64'd0);
    check({tag, "_1"}, 64'({bus1.note_addr, bus1.spr_i, bus1.spr_j, bus1.spr_id, bus1.spr_key,
                    bus1.vga_x, bus1.vga_y, bus1.vga_colour, bus1.vga_plot, bus1.busy,
                    bus1.done}), 64'd0);
  endtask

  task automatic run_pass(input int notes, input logic [2:0] frame, input bit inject, input int abort_at);
    int k, first;
    push_pass(notes, frame);
    @(negedge clock);
    busy_cycles = 0; done_count = 0; plots = 0;
    foreach (plots_note[m]) plots_note[m] = 0;
    drive_start(1'b1, frame);
    @(negedge clock);
    drive_start(1'b0, 3'd0);
    k = 0; first = -1;
    check("fetch_note_addr", 64'(s_note_addr), 64'd0);
    check("busy_after_start", 64'(s_busy), 64'd1);
    while (!s_done && k < notes * 259 + 20) begin
      @(negedge clock);
      k++;
      if (s_plot && first < 0) first = k;
      if (k == 10) begin
        check("spr_key", 64'(s_spr_key), 64'(rom_key[0]));
        check("spr_id", 64'(s_spr_id), 64'(frame));
      end
      if (k == 100) check("spr_j_upper", 64'(s_spr_j[5:4]), 64'd0);
      if (inject) begin
        if (k == 900) check("inject_in_note3", 64'(s_note_addr), 64'd3);
        drive_start(k == 900, 3'd7);
      end
      if (k == abort_at) break;
    end
    if (abort_at > 0) begin
      check("abort_in_note7", 64'(s_note_addr), 64'd7);
      #2 reset = 1'b1;
      #1 check_zero("reset_mid_draw");
      @(negedge clock);
      #2 reset = 1'b0;
      repeat (5) @(negedge clock);
      check("no_done_after_abort", 64'(done_count), 64'd0);
      exp_q.delete();
    end else begin
      check("done_cycle", 64'(k), 64'(notes * 259));
      check("first_plot_cycle", 64'(first), 64'(first_exp));
      @(negedge clock);
      check("busy_after_done", 64'(s_busy), 64'd0);
      check("done_count", 64'(done_count), 64'd1);
      check("busy_cycles", 64'(busy_cycles), 64'(notes * 259 + 1));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.frame = 3'd0;
    bus1.start = 1'b0; bus1.frame = 3'd0;
    for (int n = 0; n < 16; n++) begin rom_x[n] = 8'd10; rom_y[n] = 8'd20; rom_key[n] = 2'd2; end
    repeat (3) @(negedge clock);
    #1 check_zero("reset_outputs");
    @(negedge clock);
    #2 reset = 1'b0;

    // Uniform table: whole pass at (10,20), key D, frame 1.
    run_pass(16, 3'd1, 1'b0, -1);
    check("pass_plots", 64'(plots), 64'd4096);

    // Mixed table with edge-clipped notes; start pulsed during note 3.
    for (int n = 0; n < 16; n++) begin
      rom_x[n]   = (n % 4 == 0) ? 8'd150 : 8'(n * 9);
      rom_y[n]   = (n % 3 == 0) ? 8'd110 : 8'(n * 7);
      rom_key[n] = 2'(n % 4);
    end
    run_pass(16, 3'd6, 1'b1, -1);
    check("clipped_note0_plots", 64'(plots_note[0]), 64'd100);
    check("clip_no_wrap_total", 64'(plots), 64'(plots_note.sum()));

    // Reset during DRAW of note 7, then a fresh pass from note 0.
    run_pass(16, 3'd3, 1'b0, 1900);
    run_pass(16, 3'd3, 1'b0, -1);

    // Single-note instance with alternating 0/5 sprite columns.
    sel = 1'b1;
    spr_mode = 1;
    for (int n = 0; n < 16; n++) begin rom_x[n] = 8'd10; rom_y[n] = 8'd20; rom_key[n] = 2'd1; end
    run_pass(1, 3'd2, 1'b0, -1);
`ifdef NOTE_TRANSPARENT_EN
    check("single_note_plots", 64'(plots), 64'd128);
`else
    check("single_note_plots", 64'(plots), 64'd256);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
